// File: rtl/bldc_comm_ctrl.sv
// Sensorless six-step BLDC commutation sequencer.
//
// Runs an open-loop align and ramp-up, then hands over to closed-loop
// operation. In closed loop it samples the floating-phase back-EMF comparator
// on every rising edge of the PWM middle marker, filters for a zero crossing,
// measures the zero-crossing period and commutates half a period (30
// electrical degrees) after each crossing.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   comm_en_i       enable; low returns the sequencer to idle (all phases off)
//   pwm_middle_i    middle-of-pulse level from the PWM stage
//   bemf_i          back-EMF comparator outputs {c,b,a}
//   align_time_i    align hold length in clk cycles (0 treated as 1)
//   ramp_time_i     open-loop step length in clk cycles (0 treated as 1)
//   comm_o          commutation code: 000 off, 001..110 six-step sequence
//   zc_o            one-cycle pulse per accepted zero crossing
//   period_o        last measured zero-crossing period in clk cycles
//   locked_o        closed-loop lock indicator
//   stall_o         one-cycle pulse when no zero crossing arrives in time
module bldc_comm_ctrl #(
  parameter int unsigned CNT_DW        = 16,
  parameter int unsigned BLANK         = 2,
  parameter int unsigned FILT          = 3,
  parameter int unsigned STARTUP_STEPS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              comm_en_i,
  input  logic              pwm_middle_i,
  input  logic [2:0]        bemf_i,
  input  logic [CNT_DW-1:0] align_time_i,
  input  logic [CNT_DW-1:0] ramp_time_i,
  output logic [2:0]        comm_o,
  output logic              zc_o,
  output logic [CNT_DW-1:0] period_o,
  output logic              locked_o,
  output logic              stall_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAlign   = 3'd1;
  localparam logic [2:0] StStartup = 3'd2;
  localparam logic [2:0] StWaitZc  = 3'd3;
  localparam logic [2:0] StDelay   = 3'd4;

  localparam int unsigned BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam int unsigned FW = $clog2(FILT + 1);

  localparam logic [BW-1:0]     BlankInit   = BW'(BLANK);
  localparam logic [FW-1:0]     FiltLast    = FW'(FILT - 1);
  localparam logic [CNT_DW-1:0] CntMax      = '1;
  localparam logic [CNT_DW-1:0] CntOne      = CNT_DW'(1);
  // With one or fewer startup steps the align advance already completes startup.
  localparam bit                SkipStartup = (STARTUP_STEPS <= 1);
  localparam logic [CNT_DW-1:0] StepsLast   = SkipStartup ? CntOne : CNT_DW'(STARTUP_STEPS - 1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        comm_q, comm_d;
  logic              zc_q, zc_d;
  logic              stall_q, stall_d;
  logic              locked_q, locked_d;
  logic [CNT_DW-1:0] period_q, period_d;
  logic [CNT_DW-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_DW-1:0] steps_q, steps_d;
  logic [CNT_DW-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_DW-1:0] delay_cnt_q, delay_cnt_d;
  logic [BW-1:0]     blank_cnt_q, blank_cnt_d;
  logic [FW-1:0]     filt_cnt_q, filt_cnt_d;
  logic              mid_q;

  logic              mid_rise;
  logic              float_bit;
  logic              cross_lvl;
  logic              bemf_match;
  logic              zc_det;
  logic [2:0]        comm_next;
  logic [CNT_DW-1:0] align_load;
  logic [CNT_DW-1:0] ramp_load;
  logic [CNT_DW-1:0] period_inc;

  // Floating phase and the level its comparator settles to after the crossing.
  always_comb begin
    float_bit = 1'b0;
    cross_lvl = 1'b1;
    case (comm_q)
      3'b001: begin float_bit = bemf_i[2]; cross_lvl = 1'b0; end
      3'b010: begin float_bit = bemf_i[1]; cross_lvl = 1'b1; end
      3'b011: begin float_bit = bemf_i[0]; cross_lvl = 1'b0; end
      3'b100: begin float_bit = bemf_i[2]; cross_lvl = 1'b1; end
      3'b101: begin float_bit = bemf_i[1]; cross_lvl = 1'b0; end
      3'b110: begin float_bit = bemf_i[0]; cross_lvl = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    case (comm_q)
      3'b001:  comm_next = 3'b010;
      3'b010:  comm_next = 3'b011;
      3'b011:  comm_next = 3'b100;
      3'b100:  comm_next = 3'b101;
      3'b101:  comm_next = 3'b110;
      default: comm_next = 3'b001;
    endcase
  end

  assign mid_rise   = pwm_middle_i & ~mid_q;
  assign bemf_match = (float_bit == cross_lvl);
  // The FILT-th consecutive unblanked match is the crossing.
  assign zc_det     = (state_q == StWaitZc) && mid_rise && (blank_cnt_q == '0) &&
                      bemf_match && (filt_cnt_q == FiltLast);
  assign align_load = (align_time_i == '0) ? CntOne : align_time_i;
  assign ramp_load  = (ramp_time_i == '0) ? CntOne : ramp_time_i;
  assign period_inc = (period_cnt_q == CntMax) ? period_cnt_q : period_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    comm_d       = comm_q;
    zc_d         = 1'b0;
    stall_d      = 1'b0;
    locked_d     = locked_q;
    period_d     = period_q;
    step_cnt_d   = step_cnt_q;
    steps_d      = steps_q;
    period_cnt_d = period_cnt_q;
    delay_cnt_d  = delay_cnt_q;
    blank_cnt_d  = blank_cnt_q;
    filt_cnt_d   = filt_cnt_q;

    if (!comm_en_i) begin
      state_d      = StIdle;
      comm_d       = 3'b000;
      locked_d     = 1'b0;
      step_cnt_d   = '0;
      steps_d      = '0;
      period_cnt_d = '0;
      delay_cnt_d  = '0;
      blank_cnt_d  = '0;
      filt_cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d    = StAlign;
          comm_d     = 3'b001;
          step_cnt_d = align_load;
        end

        StAlign: begin
          step_cnt_d = step_cnt_q - 1'b1;
          if (step_cnt_q <= CntOne) begin
            comm_d  = comm_next;
            steps_d = CntOne;
            if (SkipStartup) begin
              state_d      = StWaitZc;
              step_cnt_d   = '0;
              blank_cnt_d  = BlankInit;
              filt_cnt_d   = '0;
              period_cnt_d = '0;
            end else begin
              state_d    = StStartup;
              step_cnt_d = ramp_load;
            end
          end
        end

        StStartup: begin
          step_cnt_d = step_cnt_q - 1'b1;
          if (step_cnt_q <= CntOne) begin
            comm_d  = comm_next;
            steps_d = steps_q + 1'b1;
            if (steps_q >= StepsLast) begin
              // First entry into closed loop starts the period measurement.
              state_d      = StWaitZc;
              step_cnt_d   = '0;
              blank_cnt_d  = BlankInit;
              filt_cnt_d   = '0;
              period_cnt_d = '0;
            end else begin
              step_cnt_d = ramp_load;
            end
          end
        end

        StWaitZc: begin
          period_cnt_d = period_inc;
          if (mid_rise) begin
            if (blank_cnt_q != '0) begin
              blank_cnt_d = blank_cnt_q - 1'b1;
            end else if (bemf_match) begin
              filt_cnt_d = filt_cnt_q + 1'b1;
            end else begin
              filt_cnt_d = '0;
            end
          end
          // A crossing on the saturation cycle still wins over the timeout.
          if (zc_det) begin
            period_d     = period_cnt_q;
            delay_cnt_d  = period_cnt_q >> 1;
            period_cnt_d = '0;
            filt_cnt_d   = '0;
            locked_d     = 1'b1;
            zc_d         = 1'b1;
            state_d      = StDelay;
          end else if (period_cnt_q == CntMax) begin
            stall_d      = 1'b1;
            locked_d     = 1'b0;
            comm_d       = 3'b001;
            state_d      = StAlign;
            step_cnt_d   = align_load;
            steps_d      = '0;
            period_cnt_d = '0;
            blank_cnt_d  = '0;
            filt_cnt_d   = '0;
          end
        end

        StDelay: begin
          period_cnt_d = period_inc;
          if (delay_cnt_q == '0) begin
            comm_d      = comm_next;
            state_d     = StWaitZc;
            blank_cnt_d = BlankInit;
            filt_cnt_d  = '0;
          end else begin
            delay_cnt_d = delay_cnt_q - 1'b1;
          end
        end

        default: begin
          state_d  = StIdle;
          comm_d   = 3'b000;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      comm_q       <= 3'b000;
      zc_q         <= 1'b0;
      stall_q      <= 1'b0;
      locked_q     <= 1'b0;
      period_q     <= '0;
      step_cnt_q   <= '0;
      steps_q      <= '0;
      period_cnt_q <= '0;
      delay_cnt_q  <= '0;
      blank_cnt_q  <= '0;
      filt_cnt_q   <= '0;
      mid_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      comm_q       <= comm_d;
      zc_q         <= zc_d;
      stall_q      <= stall_d;
      locked_q     <= locked_d;
      period_q     <= period_d;
      step_cnt_q   <= step_cnt_d;
      steps_q      <= steps_d;
      period_cnt_q <= period_cnt_d;
      delay_cnt_q  <= delay_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
      filt_cnt_q   <= filt_cnt_d;
      mid_q        <= pwm_middle_i;
    end
  end

  assign comm_o   = comm_q;
  assign zc_o     = zc_q;
  assign period_o = period_q;
  assign locked_o = locked_q;
  assign stall_o  = stall_q;

endmodule

// File: doc/bldc_comm_ctrl.md
Name: bldc_comm_ctrl

Overview:
- Sensorless six-step commutation sequencer; drives the PWM stage's commutation input (comm_o feeds comm_i).
- Samples the floating-phase back-EMF comparators on each PWM-middle rising edge.
- Detects zero crossings, measures the commutation period, and commutates 30 electrical degrees later (half period).
- Provides open-loop align and ramp-up before closed-loop run.

Parameters:
- CNT_DW, 16, width of period/delay/step counters
- BLANK, 2, PWM-middle samples ignored after each commutation (demagnetisation blanking)
- FILT, 3, consecutive matching samples required to accept a zero crossing (FILT>=1)
- STARTUP_STEPS, 6, open-loop commutations before closed loop

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- comm_en_i  input  1  enable; low forces IDLE
- pwm_middle_i  input  1  middle-of-pulse level from PWM stage
- bemf_i  input  3  comparator outputs {c,b,a}; bit0 = phase a
- align_time_i  input  CNT_DW  align hold length, clk cycles
- ramp_time_i  input  CNT_DW  open-loop step length, clk cycles
- comm_o  output  3  commutation code 000 (all off), 001..110
- zc_o  output  1  one-cycle zero-crossing pulse
- period_o  output  CNT_DW  last measured ZC-to-ZC period, clk cycles
- locked_o  output  1  closed-loop lock indicator
- stall_o  output  1  one-cycle timeout pulse

Behaviour:
- Reset values:
  - comm_o=000, zc_o=0, period_o=0, locked_o=0, stall_o=0
  - state=IDLE, all counters 0
- All outputs are registered.
- Sequence: 001→010→011→100→101→110→001. No other values appear except 000.
- Floating phase / expected ZC level:
  - 001: c, 0
  - 010: b, 1
  - 011: a, 0
  - 100: c, 1
  - 101: b, 0
  - 110: a, 1
- mid_rise = pwm_middle_i & ~pwm_middle_i registered. Samples are taken only on mid_rise.
- States:
  - IDLE:
    - comm_o=000, locked_o=0.
    - comm_en_i=1 → ALIGN, comm_o=001, step_cnt loaded with max(align_time_i,1).
  - ALIGN:
    - step_cnt decrements each cycle.
    - At 1: advance comm_o, load max(ramp_time_i,1), steps=1, go STARTUP.
  - STARTUP:
    - step_cnt decrements each cycle. At 1: advance comm_o and increment steps.
    - When steps reaches STARTUP_STEPS on that advance, go WAIT_ZC instead of reloading.
    - No ZC detection in STARTUP.
  - WAIT_ZC:
    - Entry (every commutation): blank_cnt=BLANK, filt_cnt=0, period_cnt=0 on the first entry from STARTUP only.
    - On mid_rise:
      - blank_cnt!=0 → decrement, no sample.
      - Otherwise, floating bit == expected → filt_cnt++. Else filt_cnt=0.
      - The FILT-th consecutive match is a ZC.
    - On ZC, at the same edge:
      - period_o<=period_cnt, delay_cnt<=period_cnt>>1, period_cnt<=0
      - locked_o<=1, zc_o high the following cycle
      - go DELAY
  - DELAY:
    - delay_cnt==0 → advance comm_o, go WAIT_ZC.
    - Else decrement.
    - A ZC with delay 0 commutates 1 cycle after zc_o.
- period_cnt:
  - Increments every cycle in WAIT_ZC and DELAY.
  - Saturates at 2^CNT_DW-1.
- Timeout:
  - Trigger: in WAIT_ZC, period_cnt at all-ones and no ZC this cycle.
  - Response: stall_o pulse, locked_o=0, comm_o=001, go ALIGN (reload align_time_i).
  - A ZC in the same cycle wins over timeout.
- comm_en_i=0 in any state: next edge → IDLE, comm_o=000, locked_o=0, counters cleared. period_o holds.
- align_time_i/ramp_time_i are sampled at each reload; mid-step changes take effect at the next reload.
- bemf_i is used unsynchronised; the upstream comparator interface provides synchronisation.

Test Plan:
- Reset → all outputs 0. Assert comm_en_i with align_time_i=10 → comm_o=001 for exactly 10 cycles, then 010.
- ramp_time_i=20, STARTUP_STEPS=6 → comm_o advances every 20 cycles: 010,011,100,101,110. Then 001 (6th advance) and WAIT_ZC. bemf_i transitions in STARTUP ignored.
- Closed loop, comm_o=001:
  - mid_rise every 100 cycles, bemf_i[2]=1.
  - First 2 samples blanked. Drive bemf_i[2]=0 from the 3rd sample; ZC at the 5th sample.
  - Expect period_o = cycles since entry, zc_o single pulse.
  - comm_o=010 after period/2+1 cycles; locked_o=1.
- Filter: pattern match, match, mismatch, match, match, match → ZC only on the 6th sample. With FILT=1, the first unblanked match is the ZC.
- Timeout with CNT_DW=8: no matching samples → period_cnt reaches 255 → stall_o one pulse, locked_o=0, comm_o=001, align restarts.
- Drop comm_en_i during DELAY → next cycle comm_o=000, zc_o=0, period_o unchanged. Re-enable → restarts at ALIGN.
